pmem_prefetch_arbiter: RTL and testbench
========================================

Name: pmem_prefetch_arbiter

Overview:
- Sits between the prefetching L1 cache and the cacheline adapter, and owns the single physical-memory port.
- Turns the cache's prefetch_start hints into next-line read requests and holds each fetched line in a one-entry prefetch buffer for the cache.
- Arbitrates memory between cache demand traffic (fixed priority) and prefetch reads; never preempts an in-flight transaction.

Parameters:
- s_offset, 5, byte-offset bits per line (line = 32 B).
- s_line, 256, line width in bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cache_pmem_read  in  1  demand read from cache
- cache_pmem_write  in  1  demand writeback from cache
- cache_pmem_address  in  32  demand line address
- cache_pmem_wdata  in  256  writeback data
- cache_pmem_rdata  out  256  demand read data
- cache_pmem_resp  out  1  demand done
- prefetch_start  in  1  one-cycle hint from cache
- cacheline_address  in  32  address of the line that triggered the hint
- cache_way  in  1  victim way for the prefetched line
- prefetch_rdata  out  256  buffered prefetched line
- prefetch_ready  out  1  buffer valid
- pf_cline_address  out  32  line address of the buffered line
- pf_cache_way  out  1  way tag of the buffered line
- prefetch_consume  in  1  cache has taken the buffer (pulse)
- pmem_read  out  1  to cacheline adapter
- pmem_write  out  1  to cacheline adapter
- pmem_address  out  32  to cacheline adapter
- pmem_wdata  out  256  to cacheline adapter
- pmem_rdata  in  256  from cacheline adapter
- pmem_resp  in  1  from cacheline adapter

Behaviour:
- Reset: state IDLE. pf_pending=0, inflight_stale=0, buffer valid=0. All outputs 0 (pmem_*, cache_pmem_resp, prefetch_ready, pf_cline_address, pf_cache_way, prefetch_rdata).
- States:
  - IDLE: no grant.
  - DEMAND: serves a cache request.
  - PREFETCH: serves a prefetch read.
- Prefetch target: target = {cacheline_address[31:5], 5'b0} + 32.
  - If cacheline_address[31:5] is all ones, the hint is dropped (no wrap to 0).
  - A valid hint sets pf_pending=1 and captures pf_addr=target and pf_way=cache_way.
  - A new hint while pf_pending=1 overwrites it; the latest hint wins.
  - Hints are accepted in every state.
- IDLE transitions, evaluated each cycle:
  - cache_pmem_read or cache_pmem_write asserted -> DEMAND.
  - Otherwise, if pf_pending=1 -> PREFETCH, and pf_pending is cleared on that edge.
  - Demand always wins a same-cycle tie.
- DEMAND:
  - pmem_read/pmem_write mirror the cache request. pmem_address = cache_pmem_address; pmem_wdata = cache_pmem_wdata.
  - cache_pmem_rdata = pmem_rdata combinationally; cache_pmem_resp = pmem_resp.
  - On pmem_resp -> IDLE.
  - One idle cycle always separates grants.
- PREFETCH:
  - pmem_read=1, pmem_address=in-flight address, pmem_write=0. cache_pmem_resp stays 0.
  - On pmem_resp, if inflight_stale=0: load the buffer with pmem_rdata, address and way, and set valid. prefetch_ready goes high the next cycle.
  - On pmem_resp, if inflight_stale=1: discard the data.
  - Clear inflight_stale and go -> IDLE.
- Buffer:
  - Single entry. prefetch_ready = valid.
  - prefetch_consume clears valid the next cycle. prefetch_consume while valid=0 is ignored.
  - A completing prefetch overwrites a still-valid buffer.
  - A same-cycle completion and consume leaves valid=1 holding the new line.
- Coherence (address compares use bits [31:5]):
  - Any demand request granted to a line equal to pf_addr clears pf_pending.
  - A demand write matching a valid buffer line clears valid.
  - A demand write whose line matches the in-flight prefetch address sets inflight_stale. This case arises only when the write is requested during PREFETCH; it is granted after the prefetch completes, and the stale data is discarded.
- Latency:
  - Request seen in IDLE at cycle N -> pmem_read/pmem_write high at cycle N+1.
  - The request is held until pmem_resp.
  - Demand worst case waits for one full prefetch transaction.
- rst mid-transaction returns to IDLE with everything cleared. The adapter is reset by the same rst.

Test Plan:
- Hint with cacheline_address=0x0000_1040, way=1, no demand -> pmem_read at 0x0000_1060 one cycle later. After pmem_resp with data D: prefetch_ready=1, pf_cline_address=0x0000_1060, pf_cache_way=1, prefetch_rdata=D.
- Same cycle as that hint, a demand read to 0x0000_2000 -> demand granted first (pmem_address=0x2000, cache_pmem_resp pulses). Then the prefetch for 0x1060 issues after one idle cycle.
- Demand read to 0x0000_3000 arrives during an in-flight prefetch of 0x1060 -> pmem_address stays 0x1060 until pmem_resp. The demand is granted after the idle cycle; cache_pmem_resp never pulses during PREFETCH.
- Hint with cacheline_address=0xFFFF_FFE0 -> no pmem_read ever issued. Two hints back-to-back from 0x100 then 0x200 while busy -> only 0x220 is fetched.
- Demand write to 0x0000_1060 during the in-flight prefetch of 0x1060 -> prefetch data discarded and prefetch_ready stays 0. With the buffer already valid at 0x1060, the same write clears prefetch_ready.
- Assert rst during PREFETCH, then deassert -> all outputs 0 and state IDLE. A new hint afterwards behaves as in the first scenario.

Source files
------------

// File: rtl/pmem_prefetch_arbiter.sv
// Physical-memory arbiter between the L1 cache demand port and a next-line
// prefetcher, with a one-entry prefetch buffer handed back to the cache.
module pmem_prefetch_arbiter #(
    parameter int s_offset = 5,
    parameter int s_line   = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cache_pmem_read,
    input  logic              cache_pmem_write,
    input  logic [31:0]       cache_pmem_address,
    input  logic [s_line-1:0] cache_pmem_wdata,
    output logic [s_line-1:0] cache_pmem_rdata,
    output logic              cache_pmem_resp,
    input  logic              prefetch_start,
    input  logic [31:0]       cacheline_address,
    input  logic              cache_way,
    output logic [s_line-1:0] prefetch_rdata,
    output logic              prefetch_ready,
    output logic [31:0]       pf_cline_address,
    output logic              pf_cache_way,
    input  logic              prefetch_consume,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [s_line-1:0] pmem_wdata,
    input  logic [s_line-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEMAND   = 2'd1,
        PREFETCH = 2'd2
    } state_t;

    localparam logic [31:0] line_mask = ~((32'd1 << s_offset) - 32'd1);
    localparam logic [31:0] line_size = 32'd1 << s_offset;

    // Line-granular address compare (byte offset bits ignored).
    function automatic logic line_match(input logic [31:0] a, input logic [31:0] b);
        return ((a ^ b) & line_mask) == 32'd0;
    endfunction

    state_t              state_r, state_s;
    logic                pf_pending_r;
    logic [31:0]         pf_addr_r;
    logic                pf_way_r;
    logic [31:0]         inflight_addr_r;
    logic                inflight_way_r;
    logic                inflight_stale_r;
    logic                buf_valid_r;
    logic [s_line-1:0]   buf_data_r;
    logic [31:0]         buf_addr_r;
    logic                buf_way_r;

    logic                hint_valid_s;
    logic [31:0]         hint_target_s;
    logic                eff_pending_s;
    logic [31:0]         eff_addr_s;
    logic                eff_way_s;
    logic                demand_req_s;
    logic                grant_demand_s;
    logic                grant_pf_s;
    logic                pf_done_s;
    logic                stale_now_s;
    logic                buf_write_hit_s;

    // Hint decode, arbitration qualifiers and coherence hits.
    always_comb begin
        hint_valid_s    = prefetch_start && ((cacheline_address & line_mask) != line_mask);
        hint_target_s   = (cacheline_address & line_mask) + line_size;
        // A hint arriving this cycle is newer than anything already pending.
        eff_pending_s   = pf_pending_r | hint_valid_s;
        eff_addr_s      = hint_valid_s ? hint_target_s : pf_addr_r;
        eff_way_s       = hint_valid_s ? cache_way : pf_way_r;
        demand_req_s    = cache_pmem_read | cache_pmem_write;
        grant_demand_s  = (state_r == IDLE) && demand_req_s;
        grant_pf_s      = (state_r == IDLE) && !demand_req_s && eff_pending_s;
        pf_done_s       = (state_r == PREFETCH) && pmem_resp;
        // A write to the in-flight line, even on the completion cycle, makes the fetched data stale.
        stale_now_s     = inflight_stale_r ||
                          ((state_r == PREFETCH) && cache_pmem_write &&
                           line_match(cache_pmem_address, inflight_addr_r));
        buf_write_hit_s = (state_r == DEMAND) && cache_pmem_write && buf_valid_r &&
                          line_match(cache_pmem_address, buf_addr_r);
    end

    // Next-state selection and memory-port steering.
    always_comb begin
        state_s          = state_r;
        pmem_read        = 1'b0;
        pmem_write       = 1'b0;
        pmem_address     = 32'd0;
        pmem_wdata       = '0;
        cache_pmem_rdata = '0;
        cache_pmem_resp  = 1'b0;
        case (state_r)
            IDLE: begin
                if (demand_req_s) begin
                    state_s = DEMAND;
                end else if (eff_pending_s) begin
                    state_s = PREFETCH;
                end else begin
                    state_s = IDLE;
                end
            end
            DEMAND: begin
                pmem_read        = cache_pmem_read;
                pmem_write       = cache_pmem_write;
                pmem_address     = cache_pmem_address;
                pmem_wdata       = cache_pmem_wdata;
                cache_pmem_rdata = pmem_rdata;
                cache_pmem_resp  = pmem_resp;
                if (pmem_resp) begin
                    state_s = IDLE;
                end else begin
                    state_s = DEMAND;
                end
            end
            PREFETCH: begin
                pmem_read    = 1'b1;
                pmem_address = inflight_addr_r;
                if (pmem_resp) begin
                    state_s = IDLE;
                end else begin
                    state_s = PREFETCH;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, pending-hint, in-flight and buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= IDLE;
            pf_pending_r     <= 1'b0;
            pf_addr_r        <= 32'd0;
            pf_way_r         <= 1'b0;
            inflight_addr_r  <= 32'd0;
            inflight_way_r   <= 1'b0;
            inflight_stale_r <= 1'b0;
            buf_valid_r      <= 1'b0;
            buf_data_r       <= '0;
            buf_addr_r       <= 32'd0;
            buf_way_r        <= 1'b0;
        end else begin
            state_r <= state_s;

            if (grant_pf_s) begin
                pf_pending_r    <= 1'b0;
                inflight_addr_r <= eff_addr_s;
                inflight_way_r  <= eff_way_s;
            end else if (grant_demand_s && eff_pending_s &&
                         line_match(cache_pmem_address, eff_addr_s)) begin
                pf_pending_r <= 1'b0;
            end else if (hint_valid_s) begin
                pf_pending_r <= 1'b1;
                pf_addr_r    <= hint_target_s;
                pf_way_r     <= cache_way;
            end

            inflight_stale_r <= pf_done_s ? 1'b0 : stale_now_s;

            // A fresh line wins over a same-cycle consume.
            if (pf_done_s && !stale_now_s) begin
                buf_valid_r <= 1'b1;
                buf_data_r  <= pmem_rdata;
                buf_addr_r  <= inflight_addr_r;
                buf_way_r   <= inflight_way_r;
            end else if (prefetch_consume || buf_write_hit_s) begin
                buf_valid_r <= 1'b0;
            end
        end
    end

    assign prefetch_ready   = buf_valid_r;
    assign prefetch_rdata   = buf_data_r;
    assign pf_cline_address = buf_addr_r;
    assign pf_cache_way     = buf_way_r;

endmodule

// File: tb/tb_pmem_prefetch_arbiter.sv
// Directed bench for pmem_prefetch_arbiter; the bench plays both the cache
// and the cacheline adapter and checks hand-computed values.
module tb_pmem_prefetch_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         cache_pmem_read, cache_pmem_write;
    logic [31:0]  cache_pmem_address;
    logic [255:0] cache_pmem_wdata, cache_pmem_rdata;
    logic         cache_pmem_resp;
    logic         prefetch_start;
    logic [31:0]  cacheline_address;
    logic         cache_way;
    logic [255:0] prefetch_rdata;
    logic         prefetch_ready;
    logic [31:0]  pf_cline_address;
    logic         pf_cache_way;
    logic         prefetch_consume;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [255:0] D1 = {8{32'hA5A5_0001}};
    localparam logic [255:0] D2 = {8{32'h5A5A_0002}};
    localparam logic [255:0] D3 = {8{32'h1234_0003}};
    localparam logic [255:0] D4 = {8{32'hCAFE_0004}};
    localparam logic [255:0] D5 = {8{32'hBEEF_0005}};
    localparam logic [255:0] D6 = {8{32'hDEAD_0006}};
    localparam logic [255:0] D7 = {8{32'h0F0F_0007}};
    localparam logic [255:0] W1 = {8{32'h7777_00AA}};

    pmem_prefetch_arbiter #(.s_offset(5), .s_line(256)) dut (
        .clk(clk), .rst(rst),
        .cache_pmem_read(cache_pmem_read), .cache_pmem_write(cache_pmem_write),
        .cache_pmem_address(cache_pmem_address), .cache_pmem_wdata(cache_pmem_wdata),
        .cache_pmem_rdata(cache_pmem_rdata), .cache_pmem_resp(cache_pmem_resp),
        .prefetch_start(prefetch_start), .cacheline_address(cacheline_address),
        .cache_way(cache_way), .prefetch_rdata(prefetch_rdata),
        .prefetch_ready(prefetch_ready), .pf_cline_address(pf_cline_address),
        .pf_cache_way(pf_cache_way), .prefetch_consume(prefetch_consume),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(); cyc(); settle();
        n_checks++; if ({pmem_read, pmem_write, cache_pmem_resp, prefetch_ready, pf_cache_way} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {pmem_read, pmem_write, cache_pmem_resp, prefetch_ready, pf_cache_way}); end
        n_checks++; if ({pmem_address, pf_cline_address} !== 64'd0) begin n_fail++; $display("FAIL reset_addr: got %h/%h want 0", pmem_address, pf_cline_address); end
        n_checks++; if ((pmem_wdata | prefetch_rdata | cache_pmem_rdata) !== 256'd0) begin n_fail++; $display("FAIL reset_data: got nonzero data, want 0"); end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_basic_prefetch();
        prefetch_start = 1'b1; cacheline_address = 32'h0000_1040; cache_way = 1'b1;
        cyc();
        prefetch_start = 1'b0; settle();
        n_checks++; if (pmem_read !== 1'b1) begin n_fail++; $display("FAIL basic_pmem_read: got %b want 1", pmem_read); end
        n_checks++; if (pmem_address !== 32'h0000_1060) begin n_fail++; $display("FAIL basic_pmem_address: got %h want 00001060", pmem_address); end
        n_checks++; if (pmem_write !== 1'b0) begin n_fail++; $display("FAIL basic_pmem_write: got %b want 0", pmem_write); end
        pmem_resp = 1'b1; pmem_rdata = D1; settle();
        n_checks++; if (cache_pmem_resp !== 1'b0) begin n_fail++; $display("FAIL basic_no_cache_resp: got %b want 0", cache_pmem_resp); end
        cyc();
        pmem_resp = 1'b0; pmem_rdata = '0; settle();
        n_checks++; if (prefetch_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b want 1", prefetch_ready); end
        n_checks++; if (pf_cline_address !== 32'h0000_1060) begin n_fail++; $display("FAIL basic_cline: got %h want 00001060", pf_cline_address); end
        n_checks++; if (pf_cache_way !== 1'b1) begin n_fail++; $display("FAIL basic_way: got %b want 1", pf_cache_way); end
        n_checks++; if (prefetch_rdata !== D1) begin n_fail++; $display("FAIL basic_rdata: got %h want %h", prefetch_rdata[31:0], D1[31:0]); end
        n_checks++; if (pmem_read !== 1'b0) begin n_fail++; $display("FAIL basic_released: got %b want 0", pmem_read); end
    endtask

    task automatic test_demand_tie();
        prefetch_start = 1'b1; cacheline_address = 32'h0000_1040; cache_way = 1'b0;
        cache_pmem_read = 1'b1; cache_pmem_address = 32'h0000_2000;
        cyc();
        prefetch_start = 1'b0; settle();
        n_checks++; if ({pmem_read, pmem_address} !== {1'b1, 32'h0000_2000}) begin n_fail++; $display("FAIL tie_demand_first: got %b/%h want 1/00002000", pmem_read, pmem_address); end
        n_checks++; if (cache_pmem_resp !== 1'b0) begin n_fail++; $display("FAIL tie_resp_early: got %b want 0", cache_pmem_resp); end
        pmem_resp = 1'b1; pmem_rdata = D2; settle();
        n_checks++; if ({cache_pmem_resp, cache_pmem_rdata} !== {1'b1, D2}) begin n_fail++; $display("FAIL tie_resp_data: got %b/%h want 1/%h", cache_pmem_resp, cache_pmem_rdata[31:0], D2[31:0]); end
        cyc();
        cache_pmem_read = 1'b0; pmem_resp = 1'b0; pmem_rdata = '0; settle();
        n_checks++; if ({pmem_read, cache_pmem_resp} !== 2'b00) begin n_fail++; $display("FAIL tie_idle_gap: got %b want 00", {pmem_read, cache_pmem_resp}); end
        cyc(); settle();
        n_checks++; if ({pmem_read, pmem_address} !== {1'b1, 32'h0000_1060}) begin n_fail++; $display("FAIL tie_prefetch_after: got %b/%h want 1/00001060", pmem_read, pmem_address); end
        pmem_resp = 1'b1; pmem_rdata = D3;
        cyc();
        pmem_resp = 1'b0; settle();
        n_checks++; if ({prefetch_rdata, pf_cache_way} !== {D3, 1'b0}) begin n_fail++; $display("FAIL tie_buffer: got %h/%b want %h/0", prefetch_rdata[31:0], pf_cache_way, D3[31:0]); end
    endtask

    task automatic test_demand_during_prefetch();
        prefetch_start = 1'b1; cacheline_address = 32'h0000_1040; cache_way = 1'b1;
        cyc();
        prefetch_start = 1'b0; cache_pmem_read = 1'b1; cache_pmem_address = 32'h0000_3000;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_checks++; if ({pmem_address, cache_pmem_resp} !== {32'h0000_1060, 1'b0}) begin n_fail++; $display("FAIL nopreempt_%0d: got %h/%b want 00001060/0", i, pmem_address, cache_pmem_resp); end
            cyc();
        end
        pmem_resp = 1'b1; pmem_rdata = D4; settle();
        n_checks++; if ({pmem_address, cache_pmem_resp} !== {32'h0000_1060, 1'b0}) begin n_fail++; $display("FAIL nopreempt_resp: got %h/%b want 00001060/0", pmem_address, cache_pmem_resp); end
        cyc();
        pmem_resp = 1'b0; pmem_rdata = '0; settle();
        n_checks++; if (pmem_read !== 1'b0) begin n_fail++; $display("FAIL nopreempt_gap: got %b want 0", pmem_read); end
        cyc(); settle();
        n_checks++; if ({pmem_read, pmem_address} !== {1'b1, 32'h0000_3000}) begin n_fail++; $display("FAIL nopreempt_demand: got %b/%h want 1/00003000", pmem_read, pmem_address); end
        pmem_resp = 1'b1;
        cyc();
        pmem_resp = 1'b0; cache_pmem_read = 1'b0;
    endtask

    task automatic test_hint_drop_and_overwrite();
        prefetch_start = 1'b1; cacheline_address = 32'hFFFF_FFE0;
        cyc();
        prefetch_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            n_checks++; if (pmem_read !== 1'b0) begin n_fail++; $display("FAIL drop_top_%0d: got %b want 0", i, pmem_read); end
            cyc();
        end
        cache_pmem_read = 1'b1; cache_pmem_address = 32'h0000_4000;
        cyc();
        prefetch_start = 1'b1; cacheline_address = 32'h0000_0100; cache_way = 1'b0;
        cyc();
        cacheline_address = 32'h0000_0200; cache_way = 1'b1;
        cyc();
        prefetch_start = 1'b0; pmem_resp = 1'b1;
        cyc();
        pmem_resp = 1'b0; cache_pmem_read = 1'b0;
        cyc(); settle();
        n_checks++; if ({pmem_read, pmem_address} !== {1'b1, 32'h0000_0220}) begin n_fail++; $display("FAIL latest_hint: got %b/%h want 1/00000220", pmem_read, pmem_address); end
        // completion and consume of the old line in the same cycle
        pmem_resp = 1'b1; pmem_rdata = D5; prefetch_consume = 1'b1;
        cyc();
        pmem_resp = 1'b0; pmem_rdata = '0; prefetch_consume = 1'b0; settle();
        n_checks++; if ({prefetch_ready, pf_cline_address, prefetch_rdata} !== {1'b1, 32'h0000_0220, D5}) begin n_fail++; $display("FAIL consume_race: got %b/%h/%h want 1/00000220/%h", prefetch_ready, pf_cline_address, prefetch_rdata[31:0], D5[31:0]); end
        for (int i = 0; i < 3; i++) begin
            cyc(); settle();
            n_checks++; if (pmem_read !== 1'b0) begin n_fail++; $display("FAIL single_fetch_%0d: got %b want 0", i, pmem_read); end
        end
        prefetch_consume = 1'b1;
        cyc();
        prefetch_consume = 1'b0; settle();
        n_checks++; if (prefetch_ready !== 1'b0) begin n_fail++; $display("FAIL consume_clear: got %b want 0", prefetch_ready); end
    endtask

    task automatic test_write_coherence();
        prefetch_start = 1'b1; cacheline_address = 32'h0000_1040; cache_way = 1'b1;
        cyc();
        prefetch_start = 1'b0;
        cache_pmem_write = 1'b1; cache_pmem_address = 32'h0000_1060; cache_pmem_wdata = W1;
        cyc();
        pmem_resp = 1'b1; pmem_rdata = D6;
        cyc();
        pmem_resp = 1'b0; pmem_rdata = '0; settle();
        n_checks++; if ({prefetch_ready, pmem_write} !== 2'b00) begin n_fail++; $display("FAIL stale_discard: got %b want 00", {prefetch_ready, pmem_write}); end
        cyc(); settle();
        n_checks++; if ({pmem_write, pmem_read, pmem_address, pmem_wdata} !== {1'b1, 1'b0, 32'h0000_1060, W1}) begin n_fail++; $display("FAIL stale_write_grant: got %b%b/%h want 10/00001060", pmem_write, pmem_read, pmem_address); end
        pmem_resp = 1'b1;
        cyc();
        pmem_resp = 1'b0; cache_pmem_write = 1'b0; settle();
        n_checks++; if (prefetch_ready !== 1'b0) begin n_fail++; $display("FAIL stale_ready: got %b want 0", prefetch_ready); end
        prefetch_start = 1'b1; cacheline_address = 32'h0000_1040;
        cyc();
        prefetch_start = 1'b0; pmem_resp = 1'b1; pmem_rdata = D7;
        cyc();
        pmem_resp = 1'b0; pmem_rdata = '0; settle();
        n_checks++; if ({prefetch_ready, prefetch_rdata} !== {1'b1, D7}) begin n_fail++; $display("FAIL refill: got %b/%h want 1/%h", prefetch_ready, prefetch_rdata[31:0], D7[31:0]); end
        cache_pmem_write = 1'b1; cache_pmem_address = 32'h0000_1060;
        cyc();
        pmem_resp = 1'b1;
        cyc();
        pmem_resp = 1'b0; cache_pmem_write = 1'b0; settle();
        n_checks++; if (prefetch_ready !== 1'b0) begin n_fail++; $display("FAIL write_invalidate: got %b want 0", prefetch_ready); end
    endtask

    task automatic test_reset_mid();
        prefetch_start = 1'b1; cacheline_address = 32'h0000_1040; cache_way = 1'b1;
        cyc();
        prefetch_start = 1'b0; pmem_resp = 1'b1; pmem_rdata = D2;
        cyc();
        pmem_resp = 1'b0; pmem_rdata = '0;
        prefetch_start = 1'b1; cacheline_address = 32'h0000_2040;
        cyc();
        prefetch_start = 1'b0; settle();
        n_checks++; if ({pmem_read, pmem_address, prefetch_ready} !== {1'b1, 32'h0000_2060, 1'b1}) begin n_fail++; $display("FAIL premid: got %b/%h/%b want 1/00002060/1", pmem_read, pmem_address, prefetch_ready); end
        rst = 1'b1;
        cyc();
        rst = 1'b0; settle();
        n_checks++; if ({pmem_read, pmem_write, cache_pmem_resp, prefetch_ready, pf_cache_way, pmem_address, pf_cline_address} !== 69'd0) begin n_fail++; $display("FAIL midrst_outputs: got %b%b%b%b%b/%h/%h want all 0", pmem_read, pmem_write, cache_pmem_resp, prefetch_ready, pf_cache_way, pmem_address, pf_cline_address); end
        n_checks++; if (prefetch_rdata !== 256'd0) begin n_fail++; $display("FAIL midrst_rdata: got %h want 0", prefetch_rdata[31:0]); end
        cyc(); settle();
        n_checks++; if (pmem_read !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: got %b want 0", pmem_read); end
        test_basic_prefetch();
    endtask

    initial begin
        rst = 1'b1;
        cache_pmem_read = 1'b0; cache_pmem_write = 1'b0;
        cache_pmem_address = 32'd0; cache_pmem_wdata = '0;
        prefetch_start = 1'b0; cacheline_address = 32'd0; cache_way = 1'b0;
        prefetch_consume = 1'b0; pmem_rdata = '0; pmem_resp = 1'b0;
        test_reset();
        test_basic_prefetch();
        test_demand_tie();
        test_demand_during_prefetch();
        test_hint_drop_and_overwrite();
        test_write_coherence();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
